// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC scheduler slice.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    localparam int unsigned CORDIC_DATA_W = 8;
    localparam logic [CORDIC_DATA_W-1:0] CORDIC_X_INIT = 8'd75;
    localparam logic [CORDIC_DATA_W-1:0] CORDIC_Y_INIT = 8'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from last+1.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IW = $clog2(N);

    logic        found;
    int unsigned cand;

    // Rotating priority search, wrapping modulo N.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = 32'(last) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[IW'(cand)]) begin
                found             = 1'b1;
                grant[IW'(cand)]  = 1'b1;
                idx               = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Round-robin scheduler sharing one iterative CORDIC core among NUM_CH requesters.
module cordic_rr_scheduler
    import cordic_pkg::*;
#(
    parameter int unsigned              NUM_CH  = 4,
    parameter int unsigned              DATA_W  = CORDIC_DATA_W,
    parameter logic [DATA_W-1:0]        X_INIT  = CORDIC_X_INIT,
    parameter logic [DATA_W-1:0]        Y_INIT  = CORDIC_Y_INIT,
    parameter int unsigned              TIMEOUT = 31
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_CH-1:0]           req_valid_strobe_i,
    input  logic [NUM_CH*DATA_W-1:0]    req_z_i,
    output logic [NUM_CH-1:0]           req_pending_o,
    output logic [NUM_CH-1:0]           req_drop_strobe_o,
    output logic [NUM_CH-1:0]           res_valid_strobe_o,
    output logic [$clog2(NUM_CH)-1:0]   res_ch_o,
    output logic [DATA_W-1:0]           res_x_o,
    output logic [DATA_W-1:0]           res_y_o,
    output logic                        timeout_strobe_o,
    output logic [DATA_W-1:0]           cordic_x_o,
    output logic [DATA_W-1:0]           cordic_y_o,
    output logic [DATA_W-1:0]           cordic_z_o,
    output logic                        cordic_valid_strobe_o,
    input  logic [DATA_W-1:0]           cordic_x_i,
    input  logic [DATA_W-1:0]           cordic_y_i,
    input  logic                        cordic_valid_strobe_i
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   slot [NUM_CH];
    logic [CH_W-1:0]     cur_ch;
    logic [CH_W-1:0]     last_grant;
    logic [CNT_W-1:0]    cnt;

    logic [NUM_CH-1:0]   grant_c;
    logic [CH_W-1:0]     grant_idx_c;
    logic                grant_load_c;
    logic                issue_c;
    logic                result_c;
    logic                timeout_c;
    logic [NUM_CH-1:0]   cur_mask_c;
    logic [NUM_CH-1:0]   clear_c;
    logic [NUM_CH-1:0]   accept_c;

    rr_arbiter #(
        .N     (NUM_CH)
    ) u_arb (
        .req   (req_pending_o),
        .last  (last_grant),
        .grant (grant_c),
        .idx   (grant_idx_c)
    );

    // Slot bookkeeping: the ISSUE clear frees the in-flight slot, and a same-cycle set wins.
    assign cur_mask_c = NUM_CH'(1) << cur_ch;
    assign clear_c    = issue_c ? cur_mask_c : '0;
    assign accept_c   = req_valid_strobe_i & (~req_pending_o | clear_c);

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_next   = state;
        grant_load_c = 1'b0;
        issue_c      = 1'b0;
        result_c     = 1'b0;
        timeout_c    = 1'b0;
        case (state)
            IDLE: begin
                if (|grant_c) begin
                    grant_load_c = 1'b1;
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                issue_c    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (cordic_valid_strobe_i) begin
                    result_c   = 1'b1;
                    state_next = DELIVER;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_c  = 1'b1;
                    state_next = IDLE;
                end
            end
            DELIVER: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant tracking; reset points last_grant at the top channel so channel 0 goes first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_ch     <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (grant_load_c) begin
            cur_ch     <= grant_idx_c;
            last_grant <= grant_idx_c;
        end
    end

    // Per-channel angle slots, pending flags and drop strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_pending_o     <= '0;
            req_drop_strobe_o <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                slot[k] <= '0;
            end
        end else begin
            req_pending_o     <= (req_pending_o & ~clear_c) | accept_c;
            req_drop_strobe_o <= req_valid_strobe_i & ~accept_c;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (accept_c[k]) begin
                    slot[k] <= req_z_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // WAIT cycle counter; starts at 1 so the timeout strobe lands TIMEOUT cycles after issue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (issue_c) begin
            cnt <= CNT_W'(1);
        end else if (state == WAIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Core-side outputs, loaded on grant so the start strobe coincides with ISSUE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cordic_valid_strobe_o <= 1'b0;
            cordic_x_o            <= '0;
            cordic_y_o            <= '0;
            cordic_z_o            <= '0;
        end else begin
            cordic_valid_strobe_o <= grant_load_c;
            if (grant_load_c) begin
                cordic_x_o <= X_INIT;
                cordic_y_o <= Y_INIT;
                cordic_z_o <= slot[grant_idx_c];
            end
        end
    end

    // Result capture and one-cycle result / timeout strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_valid_strobe_o <= '0;
            res_ch_o           <= '0;
            res_x_o            <= '0;
            res_y_o            <= '0;
            timeout_strobe_o   <= 1'b0;
        end else begin
            res_valid_strobe_o <= result_c ? cur_mask_c : '0;
            timeout_strobe_o   <= timeout_c;
            if (result_c) begin
                res_ch_o <= cur_ch;
                res_x_o  <= cordic_x_i;
                res_y_o  <= cordic_y_i;
            end
        end
    end

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Scoreboard bench for cordic_rr_scheduler with a simple latency-based core model.
module tb_cordic_rr_scheduler;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] x;
        logic [7:0] y;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  req_valid_strobe_i;
    logic [31:0] req_z_i;
    logic [3:0]  req_pending_o;
    logic [3:0]  req_drop_strobe_o;
    logic [3:0]  res_valid_strobe_o;
    logic [1:0]  res_ch_o;
    logic [7:0]  res_x_o;
    logic [7:0]  res_y_o;
    logic        timeout_strobe_o;
    logic [7:0]  cordic_x_o;
    logic [7:0]  cordic_y_o;
    logic [7:0]  cordic_z_o;
    logic        cordic_valid_strobe_o;
    logic [7:0]  cordic_x_i;
    logic [7:0]  cordic_y_i;
    logic        cordic_valid_strobe_i;

    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   drop_cnt = 0;
    int   to_cnt   = 0;
    int   last_iss_cyc = 0;
    int   done_cyc = -100;
    logic core_en = 1'b1;
    int   stray_req = 0;

    logic [7:0] exp_iss[$];
    res_t       exp_res[$];

    cordic_rr_scheduler dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .req_valid_strobe_i    (req_valid_strobe_i),
        .req_z_i               (req_z_i),
        .req_pending_o         (req_pending_o),
        .req_drop_strobe_o     (req_drop_strobe_o),
        .res_valid_strobe_o    (res_valid_strobe_o),
        .res_ch_o              (res_ch_o),
        .res_x_o               (res_x_o),
        .res_y_o               (res_y_o),
        .timeout_strobe_o      (timeout_strobe_o),
        .cordic_x_o            (cordic_x_o),
        .cordic_y_o            (cordic_y_o),
        .cordic_z_o            (cordic_z_o),
        .cordic_valid_strobe_o (cordic_valid_strobe_o),
        .cordic_x_i            (cordic_x_i),
        .cordic_y_i            (cordic_y_i),
        .cordic_valid_strobe_i (cordic_valid_strobe_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Core model: answers x=~z, y=z+3 exactly 10 cycles after a start strobe.
    initial begin : core_model
        int         cnt_left;
        logic       busy;
        logic [7:0] z;
        int         stray_seen;
        busy = 1'b0; cnt_left = 0; z = '0; stray_seen = 0;
        cordic_valid_strobe_i = 1'b0; cordic_x_i = '0; cordic_y_i = '0;
        forever begin
            @(negedge clk);
            cordic_valid_strobe_i = 1'b0;
            if (busy) begin
                if (cnt_left == 1) begin
                    cordic_x_i = ~z;
                    cordic_y_i = z + 8'd3;
                    cordic_valid_strobe_i = 1'b1;
                    done_cyc = cyc;
                    busy = 1'b0;
                end else begin
                    cnt_left--;
                end
            end
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                cordic_x_i = 8'h11;
                cordic_y_i = 8'h22;
                cordic_valid_strobe_i = 1'b1;
            end
            if (cordic_valid_strobe_o && core_en) begin
                busy = 1'b1;
                cnt_left = 10;
                z = cordic_z_o;
            end
        end
    end

    // Issue monitor: every core start must match the next expected angle.
    initial forever begin
        @(negedge clk);
        if (cordic_valid_strobe_o) begin
            last_iss_cyc = cyc;
            if (exp_iss.size() == 0) begin
                total++;
                $display("FAIL unexpected_issue: got z=%0d, expected none", cordic_z_o);
            end else begin
                logic [7:0] ez;
                ez = exp_iss.pop_front();
                check("issue_z", 32'(cordic_z_o), 32'(ez));
                check("issue_x", 32'(cordic_x_o), 75);
                check("issue_y", 32'(cordic_y_o), 0);
            end
        end
    end

    // Result monitor: pops the scoreboard whenever a result strobe appears.
    initial forever begin
        @(negedge clk);
        if (|res_valid_strobe_o) begin
            if (exp_res.size() == 0) begin
                total++;
                $display("FAIL unexpected_result: got ch=%0d strobe=%b, expected none", res_ch_o, res_valid_strobe_o);
            end else begin
                res_t e;
                e = exp_res.pop_front();
                check("res_strobe", 32'(res_valid_strobe_o), 32'(4'b0001 << e.ch));
                check("res_ch", 32'(res_ch_o), 32'(e.ch));
                check("res_x", 32'(res_x_o), 32'(e.x));
                check("res_y", 32'(res_y_o), 32'(e.y));
                check("res_latency", 32'(cyc - done_cyc), 1);
            end
        end
    end

    // Drop and timeout monitors.
    initial forever begin
        @(negedge clk);
        drop_cnt += $countones(req_drop_strobe_o);
        if (timeout_strobe_o) begin
            to_cnt++;
            check("timeout_latency", 32'(cyc - last_iss_cyc), 31);
        end
    end

    task automatic pulse(input logic [3:0] mask, input logic [31:0] zv);
        req_valid_strobe_i = mask;
        req_z_i = zv;
        @(negedge clk);
        req_valid_strobe_i = '0;
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_iss.size() != 0 || exp_res.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_iss.size() != 0 || exp_res.size() != 0) begin
            total++;
            $display("FAIL %s: drain timeout, %0d issues and %0d results outstanding, expected 0", name, exp_iss.size(), exp_res.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_issue(input logic [7:0] z, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (cordic_valid_strobe_o && cordic_z_o == z) found = 1'b1;
        end
        if (!found) begin
            total++;
            $display("FAIL %s: no issue of z=%0d within 200 cycles, expected one", name, z);
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_i = 1'b1;
        req_valid_strobe_i = '0;
        req_z_i = '0;
        repeat (3) @(negedge clk);
        check("rst_pending", 32'(req_pending_o), 0);
        check("rst_drop", 32'(req_drop_strobe_o), 0);
        check("rst_res_valid", 32'(res_valid_strobe_o), 0);
        check("rst_res_x", 32'(res_x_o), 0);
        check("rst_timeout", 32'(timeout_strobe_o), 0);
        check("rst_core_valid", 32'(cordic_valid_strobe_o), 0);
        check("rst_core_x", 32'(cordic_x_o), 0);
        check("rst_core_z", 32'(cordic_z_o), 0);
        rst_i = 1'b0;
        @(negedge clk);

        // Round-robin: all four at once, issued 0,1,2,3.
        exp_iss.push_back(8'd10); exp_iss.push_back(8'd20);
        exp_iss.push_back(8'd30); exp_iss.push_back(8'd40);
        exp_res.push_back('{2'd0, 8'hF5, 8'h0D});
        exp_res.push_back('{2'd1, 8'hEB, 8'h17});
        exp_res.push_back('{2'd2, 8'hE1, 8'h21});
        exp_res.push_back('{2'd3, 8'hD7, 8'h2B});
        pulse(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10});
        check("rr_pending", 32'(req_pending_o), 'b1111);
        drain(300, "rr");
        check("rr_no_drops", 32'(drop_cnt), 0);

        // Single request on ch2 with latency checks.
        exp_iss.push_back(8'd32);
        exp_res.push_back('{2'd2, 8'hDF, 8'h23});
        pulse(4'b0100, {8'd0, 8'd32, 8'd0, 8'd0});
        check("single_pending", 32'(req_pending_o), 'b0100);
        @(negedge clk);
        check("single_issue_strobe", 32'(cordic_valid_strobe_o), 1);
        check("single_issue_z", 32'(cordic_z_o), 32);
        drain(100, "single");

        // Overflow on ch1 while ch0 is busy, then a request in ch1's ISSUE cycle.
        exp_iss.push_back(8'd50); exp_iss.push_back(8'd10); exp_iss.push_back(8'd60);
        exp_res.push_back('{2'd0, 8'hCD, 8'h35});
        exp_res.push_back('{2'd1, 8'hF5, 8'h0D});
        exp_res.push_back('{2'd1, 8'hC3, 8'h3F});
        pulse(4'b0001, {8'd0, 8'd0, 8'd0, 8'd50});
        pulse(4'b0010, {8'd0, 8'd0, 8'd10, 8'd0});
        pulse(4'b0010, {8'd0, 8'd0, 8'd20, 8'd0});
        check("ovf_drop_strobe", 32'(req_drop_strobe_o), 'b0010);
        wait_issue(8'd10, "ovf_wait_ch1");
        pulse(4'b0010, {8'd0, 8'd0, 8'd60, 8'd0});
        check("ovf_same_cycle_pending", 32'(req_pending_o[1]), 1);
        check("ovf_same_cycle_no_drop", 32'(req_drop_strobe_o), 0);
        drain(300, "ovf");
        check("ovf_drop_count", 32'(drop_cnt), 1);

        // Timeout: ch3 is never answered, ch0 runs normally afterwards.
        core_en = 1'b0;
        exp_iss.push_back(8'd70); exp_iss.push_back(8'd80);
        exp_res.push_back('{2'd0, 8'hAF, 8'h53});
        pulse(4'b1001, {8'd70, 8'd0, 8'd0, 8'd80});
        wait_issue(8'd70, "to_wait_ch3");
        @(negedge clk);
        core_en = 1'b1;
        drain(300, "timeout");
        check("timeout_count", 32'(to_cnt), 1);

        // Stray core strobe while idle must be ignored.
        stray_req++;
        repeat (6) @(negedge clk);
        check("stray_res_x", 32'(res_x_o), 'hAF);
        check("stray_res_y", 32'(res_y_o), 'h53);
        check("stray_res_ch", 32'(res_ch_o), 0);

        // Async reset mid-WAIT, late core result, then channel 0 first.
        exp_iss.push_back(8'd90);
        pulse(4'b0100, {8'd0, 8'd90, 8'd0, 8'd0});
        wait_issue(8'd90, "rst_wait_ch2");
        repeat (3) @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        check("arst_pending", 32'(req_pending_o), 0);
        check("arst_core_z", 32'(cordic_z_o), 0);
        check("arst_core_x", 32'(cordic_x_o), 0);
        check("arst_res_x", 32'(res_x_o), 0);
        check("arst_res_ch", 32'(res_ch_o), 0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        repeat (12) @(negedge clk);
        check("late_result_ignored", 32'(res_x_o), 0);
        check("late_no_timeout", 32'(to_cnt), 1);
        exp_iss.push_back(8'd100); exp_iss.push_back(8'd110);
        exp_res.push_back('{2'd0, 8'h9B, 8'h67});
        exp_res.push_back('{2'd3, 8'h91, 8'h71});
        pulse(4'b1001, {8'd110, 8'd0, 8'd0, 8'd100});
        drain(300, "post_reset");

        check("final_issue_queue", 32'(exp_iss.size()), 0);
        check("final_result_queue", 32'(exp_res.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
